// File: rtl/scan_chain_controller.sv
// rtl/scan_chain_controller.sv - scan chain load/capture/unload controller with response compare
// Optional feature: define SCAN_CTRL_MASK_EN to add a compare_mask input that excludes bits from the compare.
module scan_chain_controller #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_CTRL_MASK_EN
    input  logic [CHAIN_LEN-1:0] compare_mask,
`endif
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [7:0]           fail_count
);

    localparam int CW = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t                state, next_state;
    logic [CW-1:0]         cnt;
    logic [CHAIN_LEN-1:0]  shift_q;
    logic [CHAIN_LEN-1:0]  exp_q;
    logic [CHAIN_LEN-1:0]  cap_next;
    logic                  mismatch;
    logic                  cnt_last;

`ifdef SCAN_CTRL_MASK_EN
    logic [CHAIN_LEN-1:0]  mask_q;
`endif

    assign cnt_last = (cnt == LAST);

    // shift_q serialises the pattern MSB first, then collects the unloaded response
    assign cap_next = {shift_q[CHAIN_LEN-2:0], scan_out};

`ifdef SCAN_CTRL_MASK_EN
    assign mismatch = |((cap_next ^ exp_q) & ~mask_q);
`else
    assign mismatch = |(cap_next ^ exp_q);
`endif

    always_comb begin
        next_state = state;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = SHIFT_IN;
            end
            SHIFT_IN: begin
                scan_en = 1'b1;
                scan_in = shift_q[CHAIN_LEN-1];
                if (cnt_last) next_state = CAPTURE;
            end
            CAPTURE: begin
                next_state = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                scan_en = 1'b1;
                if (cnt_last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_q    <= '0;
            exp_q      <= '0;
            captured   <= '0;
            pass       <= 1'b0;
            fail_count <= 8'd0;
`ifdef SCAN_CTRL_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= pattern;
                        exp_q   <= expected;
                        cnt     <= '0;
`ifdef SCAN_CTRL_MASK_EN
                        mask_q  <= compare_mask;
`endif
                    end
                end
                SHIFT_IN: begin
                    shift_q <= {shift_q[CHAIN_LEN-2:0], 1'b0};
                    cnt     <= cnt_last ? '0 : cnt + CW'(1);
                end
                SHIFT_OUT: begin
                    shift_q <= cap_next;
                    cnt     <= cnt_last ? '0 : cnt + CW'(1);
                    if (cnt_last) begin
                        captured <= cap_next;
                        pass     <= ~mismatch;
                        if (mismatch && fail_count != 8'hFF)
                            fail_count <= fail_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_controller.sv
// tb/tb_scan_chain_controller.sv - directed table-driven bench with an inverting scan chain model
module tb_scan_chain_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [7:0] expected;
    logic       scan_en;
    logic       scan_in;
    logic       scan_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured;
    logic [7:0] fail_count;
`ifdef SCAN_CTRL_MASK_EN
    logic [7:0] compare_mask = 8'h00;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_chain_controller #(.CHAIN_LEN(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pattern(pattern),
        .expected(expected),
`ifdef SCAN_CTRL_MASK_EN
        .compare_mask(compare_mask),
`endif
        .scan_en(scan_en),
        .scan_in(scan_in),
        .scan_out(scan_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .captured(captured),
        .fail_count(fail_count)
    );

    // Chain model: functional D of each cell is the inverse of its own content
    logic [7:0] chain;
    always @(posedge clk) begin
        if (rst)          chain <= 8'h00;
        else if (scan_en) chain <= {chain[6:0], scan_in};
        else              chain <= ~chain;
    end
    assign scan_out = chain[7];

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp_v;
        logic [7:0] cap;
        logic       pas;
        logic [7:0] fc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Runs one test; done_cyc is the cycle after the start edge where done was seen (-1 on timeout)
    task automatic run_test(input logic [7:0] p, input logic [7:0] e,
                            output int done_cyc, output logic [7:0] sin_seq, output int bad_ctl);
        done_cyc = -1;
        sin_seq  = 8'h00;
        bad_ctl  = 0;
        @(negedge clk);
        pattern  = p;
        expected = e;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        pattern  = ~p;
        expected = ~e;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 8) sin_seq[8-c] = scan_in;
            else if (scan_in !== 1'b0) bad_ctl++;
            if (scan_en !== ((c != 9) && (c != 18))) bad_ctl++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    int         dc;
    int         bad;
    int         ndone;
    int         busy_low;
    logic [7:0] sseq;

    initial begin
        vecs[0] = '{8'hA5, 8'h5A, 8'h5A, 1'b1, 8'd0};
        vecs[1] = '{8'hA5, 8'h00, 8'h5A, 1'b0, 8'd1};
        vecs[2] = '{8'hA5, 8'h00, 8'h5A, 1'b0, 8'd2};
        vecs[3] = '{8'hFF, 8'h00, 8'h00, 1'b1, 8'd2};
        vecs[4] = '{8'h00, 8'hFF, 8'hFF, 1'b1, 8'd2};
        vecs[5] = '{8'h3C, 8'hC3, 8'hC3, 1'b1, 8'd2};
        vecs[6] = '{8'h81, 8'h7F, 8'h7E, 1'b0, 8'd3};
        vecs[7] = '{8'h12, 8'hED, 8'hED, 1'b1, 8'd3};

        rst = 1'b1; start = 1'b0; pattern = 8'h00; expected = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, done, scan_en, scan_in, pass}, 5'b0);
        chk("reset_captured", captured, 8'h00);
        chk("reset_fail_count", fail_count, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_test(vecs[i].pat, vecs[i].exp_v, dc, sseq, bad);
            chk($sformatf("v%0d_scan_in_seq", i), sseq, vecs[i].pat);
            chk($sformatf("v%0d_ctl_seq", i), bad, 0);
            chk($sformatf("v%0d_done_cycle", i), dc, 18);
            chk($sformatf("v%0d_captured", i), captured, vecs[i].cap);
            chk($sformatf("v%0d_pass", i), pass, vecs[i].pas);
            chk($sformatf("v%0d_fail_count", i), fail_count, vecs[i].fc);
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", i), {busy, done}, 2'b00);
        end

        // start pulses at cycles 3 and 10 while busy must be ignored
        @(negedge clk);
        pattern = 8'hA5; expected = 8'h5A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; busy_low = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (busy === 1'b0 && busy_low < 0) busy_low = c;
            start = (c == 3 || c == 10);
        end
        start = 1'b0;
        chk("ignored_start_done_count", ndone, 1);
        chk("ignored_start_busy_low", busy_low, 19);

        // start held high through DONE begins a new run from the first IDLE cycle
        @(negedge clk);
        pattern = 8'h3C; expected = 8'hC3; start = 1'b1;
        @(posedge clk);
        ndone = 0; dc = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (dc < 0) dc = c;
            end
            if (c == 19) chk("held_start_idle", busy, 1'b0);
            if (c == 20) begin
                chk("held_start_restart", busy, 1'b1);
                start = 1'b0;
            end
        end
        chk("held_start_first_done", dc, 18);
        chk("held_start_done_count", ndone, 2);
        chk("held_start_pass", pass, 1'b1);

        // rst wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_priority_busy", busy, 1'b0);
        @(negedge clk);
        chk("rst_priority_stays_idle", busy, 1'b0);

        // reset during SHIFT_OUT aborts the run
        @(negedge clk);
        pattern = 8'hA5; expected = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 14; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ctl", {scan_en, busy, done}, 3'b000);
        chk("abort_captured", captured, 8'h00);
        chk("abort_fail_count", fail_count, 8'd0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // fail_count saturation
        bad = 0;
        for (int r = 0; r < 255; r++) begin
            run_test(8'hA5, 8'h00, dc, sseq, ndone);
            if (dc != 18) bad++;
        end
        chk("sat_runs_completed", bad, 0);
        chk("sat_fail_count_255", fail_count, 8'd255);
        run_test(8'hA5, 8'h00, dc, sseq, ndone);
        chk("sat_extra_done", dc, 18);
        chk("sat_fail_count_hold", fail_count, 8'd255);
        chk("sat_pass", pass, 1'b0);

`ifdef SCAN_CTRL_MASK_EN
        compare_mask = 8'h0F;
        run_test(8'hA5, 8'h55, dc, sseq, bad);
        compare_mask = 8'h00;
        chk("mask_done", dc, 18);
        chk("mask_captured", captured, 8'h5A);
        chk("mask_pass", pass, 1'b1);
        run_test(8'hA5, 8'hD5, dc, sseq, bad);
        chk("mask_unmasked_diff_fails", pass, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_controller.md
SCAN_CHAIN_CONTROLLER -- requirements
Module: scan_chain_controller

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 8, the number of scan cells in the attached chain; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1, the single clock shared with the scan chain; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to run one test; sampled only in IDLE.
REQ-005 The block SHALL have port pattern, input, CHAIN_LEN, the stimulus to load; bit i is destined for cell i.
REQ-006 The block SHALL have port expected, input, CHAIN_LEN, the expected capture response; bit i belongs to cell i.
REQ-007 The block SHALL have port scan_en, output, 1, which drives scan_en of every chain cell.
REQ-008 The block SHALL have port scan_in, output, 1, which drives scan_in of cell 0.
REQ-009 The block SHALL have port scan_out, input, 1, the scan_out of cell CHAIN_LEN-1.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when results are valid.
REQ-012 The block SHALL have port pass, output, 1, the compare result, held until the next done.
REQ-013 The block SHALL have port captured, output, CHAIN_LEN, the unloaded response; bit i is from cell i.
REQ-014 The block SHALL have port fail_count, output, 8, a saturating count of failed runs.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT and DONE, with a shift counter of width clog2(CHAIN_LEN).
REQ-016 In IDLE with start=1, the block SHALL latch pattern and expected, clear the counter, and go to SHIFT_IN; pattern and expected changes after this latch have no effect on the run.
REQ-017 SHIFT_IN SHALL last exactly CHAIN_LEN cycles with scan_en=1 and scan_in=pattern[CHAIN_LEN-1-k] in shift cycle k (MSB first), so that cell i holds pattern[i] afterwards.
REQ-018 CAPTURE SHALL last exactly 1 cycle with scan_en=0 and scan_in=0, so the chain loads its functional D inputs.
REQ-019 SHIFT_OUT SHALL last exactly CHAIN_LEN cycles with scan_en=1 and scan_in=0; at the edge ending shift cycle k the block SHALL sample scan_out into captured[CHAIN_LEN-1-k].
REQ-020 DONE SHALL last 1 cycle with done=1, then the FSM SHALL return to IDLE; pass and captured update at the edge entering DONE.
REQ-021 Latency SHALL be fixed: done is high in cycle 2*CHAIN_LEN+2 after the start-sampling edge (cycle 18 for CHAIN_LEN=8).
REQ-022 pass SHALL equal 1 when captured equals expected, else 0.
REQ-023 fail_count SHALL increment by 1 on entering DONE with pass=0, and SHALL saturate at 255 without wrapping.
REQ-024 A start asserted while busy=1 SHALL be ignored and not queued; start held high through DONE SHALL begin a new run on the first IDLE cycle.
REQ-025 scan_en SHALL be 0 in IDLE and DONE, and scan_in SHALL be 0 outside SHIFT_IN.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set FSM=IDLE and counter=0, and set scan_en, scan_in, busy, done, pass, captured and fail_count all to 0.
REQ-027 A reset mid-run SHALL abort the run: no done pulse, fail_count unchanged from its reset value 0, and scan_en=0 from the first cycle after the reset edge.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro SCAN_CTRL_MASK_EN: when defined, the block SHALL add input compare_mask[CHAIN_LEN-1:0], latched at start, and pass SHALL be 1 when ((captured ^ expected) & ~mask) equals 0.
REQ-030 When SCAN_CTRL_MASK_EN is undefined, the compare_mask port SHALL be absent and the compare SHALL be the full-width compare of REQ-022.

Verification
REQ-031 With CHAIN_LEN=8, the chain's D tied to its own pattern-invert logic, and pattern=8'hA5, expected=8'h5A, start for 1 cycle: the bench SHALL see scan_in sequence 1,0,1,0,0,1,0,1; done in cycle 18; captured=8'h5A; pass=1; fail_count=0.
REQ-032 With the same setup and expected=8'h00: the bench SHALL see pass=0 and fail_count=1; a second identical run SHALL give fail_count=2.
REQ-033 When start is pulsed at cycles 3 and 10 during a run: the bench SHALL see exactly one done, and busy low only after DONE.
REQ-034 When rst is asserted in SHIFT_OUT cycle 4: the bench SHALL see the next cycle with scan_en=0, busy=0 and captured=0, and no done.
REQ-035 With fail_count forced to 255 by 255 failing runs, one more failing run: the bench SHALL see fail_count remain 255.
REQ-036 With SCAN_CTRL_MASK_EN defined, compare_mask=8'h0F and expected differing from captured only in bits 3:0: the bench SHALL see pass=1.
